// File: rtl/rst_ctrl_sequencer.sv
// Reset release sequencer: filters PLL lock, then releases NUM_STAGES reset
// domains in order with a hold time between them, re-asserting on lock loss or sw request.
module rst_ctrl_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int LOCK_FILTER   = 8,
    parameter int HOLD_CYCLES   = 16,
    parameter int SW_RST_CYCLES = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic [1:0]            rst_cause,
    output logic [2:0]            seq_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RELEASE   = 3'd1,
        RUN       = 3'd2,
        ASSERT    = 3'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] out_q, out_d;
    logic                  ready_q, ready_d;
    logic [1:0]            cause_q, cause_d;
    logic                  rst_event;

    // One counter serves as lock filter, hold timer and assert timer:
    // only one of them is ever live in a given state.
    assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
    assign rst_event = sw_rst_req || !pll_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        cause_d = cause_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!pll_locked) begin
                    cnt_d = '0;
                end else if (cnt_inc == CNT_WIDTH'(LOCK_FILTER)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE, RUN: begin
                // A reset event wins over a release scheduled on the same edge.
                if (rst_event) begin
                    state_d = ASSERT;
                    out_d   = '0;
                    ready_d = 1'b0;
                    cause_d = {!pll_locked, sw_rst_req};
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (state_q == RELEASE) begin
                    if (cnt_inc == CNT_WIDTH'(HOLD_CYCLES)) begin
                        out_d = out_q | (NUM_STAGES'(1) << idx_q);
                        cnt_d = '0;
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ASSERT: begin
                if (sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_inc == CNT_WIDTH'(SW_RST_CYCLES)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                idx_d   = '0;
                out_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_n_out = out_q;
    assign ready     = ready_q;
    assign rst_cause = cause_q;
    assign seq_state = 3'(state_q);

endmodule

// File: doc/rst_ctrl_sequencer.md
Name: rst_ctrl_sequencer

Overview:
- Sits directly downstream of the reset bit synchronizer.
- Consumes its synchronized active-low reset plus a PLL lock indication and a software reset request.
- Releases NUM_STAGES ordered reset domains one after another, with a programmable hold time between releases.
- Re-asserts all domain resets on PLL lock loss or a software request, then re-runs the sequence; exposes ready and reset-cause status.

Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs (>=1).
- LOCK_FILTER, 8: consecutive cycles pll_locked must be high before sequencing starts (>=1).
- HOLD_CYCLES, 16: cycles between successive stage releases; also the delay before stage 0 (>=1).
- SW_RST_CYCLES, 32: minimum cycles all outputs stay asserted after an in-operation reset event (>=1).
- CNT_WIDTH, 8: counter width; must hold max(LOCK_FILTER, HOLD_CYCLES, SW_RST_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low; driven by the synchronized reset of the upstream bit synchronizer.
- pll_locked  input  1  PLL lock, already synchronous to clk.
- sw_rst_req  input  1  software reset request, level-sampled each cycle.
- rst_n_out  output  NUM_STAGES  per-domain active-low resets; bit 0 released first.
- ready  output  1  high when all stages are released (state RUN).
- rst_cause  output  2  cause of the last in-operation reset: 00 power-on, 01 sw, 10 lock loss, 11 both in the same cycle.
- seq_state  output  3  encoded FSM state for debug.

Behaviour:
- All outputs are registered.
- On rst_n low (asynchronous):
  - State goes to WAIT_LOCK; all counters and stage index clear to 0.
  - rst_n_out = all 0; ready = 0; rst_cause = 00.
- State encoding: WAIT_LOCK=0, RELEASE=1, RUN=2, ASSERT=3.
- WAIT_LOCK:
  - lock_cnt increments on each edge with pll_locked=1 and clears on any edge with pll_locked=0.
  - On the edge where lock_cnt would reach LOCK_FILTER, go to RELEASE with hold_cnt=0 and idx=0.
  - sw_rst_req is ignored in this state.
- RELEASE:
  - hold_cnt increments each edge.
  - On the edge where it would reach HOLD_CYCLES: set rst_n_out[idx]=1, clear hold_cnt, increment idx.
  - If idx was NUM_STAGES-1, go to RUN and set ready=1 on that same edge.
  - Release timing: with pll_locked high from the first edge after reset release, rst_n_out[k] rises on edge LOCK_FILTER+(k+1)*HOLD_CYCLES.
  - Released bits stay high until an ASSERT event.
- Reset event: in RELEASE or RUN, an edge with sw_rst_req=1 or pll_locked=0 does all of the following on that edge:
  - Enter ASSERT.
  - rst_n_out = all 0 and ready = 0.
  - rst_cause = {lock_loss, sw} as sampled on that edge.
  - asrt_cnt = 0.
- ASSERT:
  - asrt_cnt increments each edge.
  - sw_rst_req=1 while in ASSERT clears asrt_cnt, extending the hold; rst_cause is unchanged.
  - On the edge where asrt_cnt would reach SW_RST_CYCLES, go to WAIT_LOCK with lock_cnt=0.
  - pll_locked is ignored during ASSERT; the lock filter runs afresh in WAIT_LOCK.
- Outputs never glitch high: a stage bit only rises in RELEASE, in index order.
- NUM_STAGES=1: the first release enters RUN directly.
- rst_n asserted mid-sequence aborts immediately to the reset values above.

Test Plan:
- Power-on, defaults, pll_locked=1 throughout: rst_n_out = 000 until edge 24; 001 at edge 24, 011 at edge 40, 111 at edge 56; ready=1 at edge 56; rst_cause=00.
- Lock glitch during WAIT_LOCK (pll_locked low for 1 cycle at edge 5): lock_cnt restarts; rst_n_out[0] rises 8+16 edges after the glitch cycle.
- In RUN, pulse sw_rst_req for 1 cycle:
  - Next edge: rst_n_out=000, ready=0, rst_cause=01, seq_state=3.
  - After 32 edges: WAIT_LOCK.
  - Full sequence repeats: ready rises 32+8+48 edges after the request.
- In RELEASE with rst_n_out=001, drop pll_locked: next edge rst_n_out=000, rst_cause=10. Same edge with sw_rst_req=1 too: rst_cause=11.
- Hold sw_rst_req high for 50 cycles in ASSERT: exit occurs 32 edges after the last high sample.
- Assert rst_n mid-RELEASE (rst_n_out=011): outputs clear asynchronously without a clock edge; rst_cause=00; sequence restarts on release.
